// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute bundle for decode_stage.
// The opcode type/group encodings live here so every user of the bundle
// sees the same bit positions.

`ifndef DECODE_STAGE_DEFINES
`define DECODE_STAGE_DEFINES
`define OPCODE_COUNT        14
`define TYPE_UNKNOWN        0
`define TYPE_NOP            1
`define TYPE_ADD            2
`define TYPE_ADC            3
`define TYPE_SUB            4
`define TYPE_AND            5
`define TYPE_EOR            6
`define TYPE_OR             7
`define TYPE_MOV            8
`define TYPE_NEG            9
`define TYPE_LD_Y           10
`define TYPE_LDI            11
`define TYPE_LDS            12
`define TYPE_STS            13
`define GROUP_COUNT         11
`define GROUP_ALU_ONE_OP    0
`define GROUP_ALU_TWO_OP    1
`define GROUP_REGISTER      2
`define GROUP_LOAD_DIRECT   3
`define GROUP_LOAD_INDIRECT 4
`define GROUP_STORE_DIRECT  5
`define GROUP_STORE_INDIRECT 6
`define GROUP_ALU           7
`define GROUP_LOAD          8
`define GROUP_STORE         9
`define GROUP_MEMORY        10
`endif

interface decode_stage_if #(
  parameter int INSTR_WIDTH  = 16,
  parameter int R_ADDR_WIDTH = 5,
  parameter int IMD_WIDTH    = 16
);
  logic [INSTR_WIDTH-1:0]   in_instr;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [`OPCODE_COUNT-1:0] opcode_type;
  logic [`GROUP_COUNT-1:0]  opcode_group;
  logic [R_ADDR_WIDTH-1:0]  opcode_rd;
  logic [R_ADDR_WIDTH-1:0]  opcode_rr;
  logic [IMD_WIDTH-1:0]     opcode_imd;
  logic [2:0]               opcode_bit;
  logic                     opcode_words;

  // Fetch/consumer side.
  modport master (
    output in_instr, in_valid, out_ready,
    input  in_ready, out_valid, opcode_type, opcode_group, opcode_rd,
           opcode_rr, opcode_imd, opcode_bit, opcode_words
  );

  // Decode stage side.
  modport slave (
    input  in_instr, in_valid, out_ready,
    output in_ready, out_valid, opcode_type, opcode_group, opcode_rd,
           opcode_rr, opcode_imd, opcode_bit, opcode_words
  );
endinterface

// File: rtl/decode_stage.sv
// Registered, flow-controlled AVR instruction decode stage.
// Assembles two-word LDS/STS, presents one registered record per instruction.
//
//   state | meaning
//   S_OP  | next accepted word is an opcode
//   S_K   | next accepted word is the 16-bit address of a pending LDS/STS

module decode_stage #(
  parameter int INSTR_WIDTH    = 16,
  parameter int R_ADDR_WIDTH   = 5,
  parameter int IMD_WIDTH      = 16,
  parameter bit LONG_MEM_EN    = 1'b1,
  parameter bit HIGH_REGS_ONLY = 1'b1
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  decode_stage_if.slave bus
);

  localparam int TW = `OPCODE_COUNT;
  localparam int GW = `GROUP_COUNT;

  typedef enum logic {S_OP, S_K} state_t;

  state_t                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [TW-1:0]           type_q, type_d;
  logic [GW-1:0]           group_q, group_d;
  logic [R_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [R_ADDR_WIDTH-1:0] rr_q, rr_d;
  logic [IMD_WIDTH-1:0]    imd_q, imd_d;
  logic                    words_q, words_d;
  logic                    pend_sts_q, pend_sts_d;
  logic [R_ADDR_WIDTH-1:0] pend_reg_q, pend_reg_d;

  logic [INSTR_WIDTH-1:0]  instr;
  logic                    in_ready;
  logic                    accept;

  logic [TW-1:0]           dec_type;
  logic [R_ADDR_WIDTH-1:0] dec_rd;
  logic [R_ADDR_WIDTH-1:0] dec_rr;
  logic [IMD_WIDTH-1:0]    dec_imd;
  logic                    dec_long;
  logic                    dec_sts;
  logic                    two_op;

  function automatic logic [TW-1:0] onehot(input int idx);
    logic [TW-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Register fields address R16..R31 only when the small register file is used.
  function automatic logic [R_ADDR_WIDTH-1:0] reg_field(input logic [4:0] raw);
    logic [R_ADDR_WIDTH-1:0] r;
    r = R_ADDR_WIDTH'(raw);
    if (HIGH_REGS_ONLY) r[4] = 1'b1;
    return r;
  endfunction

  function automatic logic [GW-1:0] group_of(input logic [TW-1:0] t);
    logic [GW-1:0] g;
    g = '0;
    g[`GROUP_ALU_ONE_OP]     = t[`TYPE_NEG];
    g[`GROUP_ALU_TWO_OP]     = t[`TYPE_ADD] | t[`TYPE_ADC] | t[`TYPE_SUB] |
                               t[`TYPE_AND] | t[`TYPE_EOR] | t[`TYPE_OR];
    g[`GROUP_REGISTER]       = t[`TYPE_MOV] | t[`TYPE_LDI];
    g[`GROUP_LOAD_DIRECT]    = t[`TYPE_LDS];
    g[`GROUP_LOAD_INDIRECT]  = t[`TYPE_LD_Y];
    g[`GROUP_STORE_DIRECT]   = t[`TYPE_STS];
    g[`GROUP_STORE_INDIRECT] = 1'b0;
    g[`GROUP_ALU]            = g[`GROUP_ALU_ONE_OP] | g[`GROUP_ALU_TWO_OP];
    g[`GROUP_LOAD]           = g[`GROUP_LOAD_DIRECT] | g[`GROUP_LOAD_INDIRECT];
    g[`GROUP_STORE]          = g[`GROUP_STORE_DIRECT] | g[`GROUP_STORE_INDIRECT];
    g[`GROUP_MEMORY]         = g[`GROUP_LOAD] | g[`GROUP_STORE];
    return g;
  endfunction

  assign instr        = bus.in_instr;
  // Ready depends only on the output slot, never on in_valid.
  assign in_ready     = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && in_ready;

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.opcode_type  = type_q;
  assign bus.opcode_group = group_q;
  assign bus.opcode_rd    = rd_q;
  assign bus.opcode_rr    = rr_q;
  assign bus.opcode_imd   = imd_q;
  assign bus.opcode_bit   = 3'b000;
  assign bus.opcode_words = words_q;

  // Single-word decode of the incoming word.
  always_comb begin
    dec_type = onehot(`TYPE_UNKNOWN);
    dec_rd   = '0;
    dec_rr   = '0;
    dec_imd  = '0;
    dec_long = 1'b0;
    dec_sts  = 1'b0;
    two_op   = 1'b0;
    casez (instr[15:0])
      16'b0000_0000_0000_0000: dec_type = onehot(`TYPE_NOP);
      16'b0000_11??_????_????: begin dec_type = onehot(`TYPE_ADD); two_op = 1'b1; end
      16'b0001_11??_????_????: begin dec_type = onehot(`TYPE_ADC); two_op = 1'b1; end
      16'b0001_10??_????_????: begin dec_type = onehot(`TYPE_SUB); two_op = 1'b1; end
      16'b0010_00??_????_????: begin dec_type = onehot(`TYPE_AND); two_op = 1'b1; end
      16'b0010_01??_????_????: begin dec_type = onehot(`TYPE_EOR); two_op = 1'b1; end
      16'b0010_10??_????_????: begin dec_type = onehot(`TYPE_OR);  two_op = 1'b1; end
      16'b0010_11??_????_????: begin dec_type = onehot(`TYPE_MOV); two_op = 1'b1; end
      16'b1001_010?_????_0001: begin
        dec_type = onehot(`TYPE_NEG);
        dec_rd   = reg_field(instr[8:4]);
      end
      16'b1000_000?_????_1000: begin
        dec_type = onehot(`TYPE_LD_Y);
        dec_rd   = reg_field(instr[8:4]);
      end
      16'b1110_????_????_????: begin
        dec_type = onehot(`TYPE_LDI);
        dec_rd   = reg_field({1'b1, instr[7:4]});
        dec_imd  = IMD_WIDTH'({instr[11:8], instr[3:0]});
      end
      16'b1010_0???_????_????: begin
        dec_type = onehot(`TYPE_LDS);
        dec_rd   = reg_field({1'b1, instr[7:4]});
        dec_imd  = IMD_WIDTH'({~instr[8], instr[8], instr[10:9], instr[3:0]});
      end
      16'b1010_1???_????_????: begin
        dec_type = onehot(`TYPE_STS);
        dec_rr   = reg_field({1'b1, instr[7:4]});
        dec_imd  = IMD_WIDTH'({~instr[8], instr[8], instr[10:9], instr[3:0]});
      end
      16'b1001_000?_????_0000: begin
        if (LONG_MEM_EN) begin
          dec_long = 1'b1;
          dec_rd   = reg_field(instr[8:4]);
        end
      end
      16'b1001_001?_????_0000: begin
        if (LONG_MEM_EN) begin
          dec_long = 1'b1;
          dec_sts  = 1'b1;
          dec_rr   = reg_field(instr[8:4]);
        end
      end
      default: ;
    endcase
    if (two_op) begin
      dec_rd = reg_field(instr[8:4]);
      dec_rr = reg_field({instr[9], instr[3:0]});
    end
  end

  // Next state, pending-word latch and output record load.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    type_d      = type_q;
    group_d     = group_q;
    rd_d        = rd_q;
    rr_d        = rr_q;
    imd_d       = imd_q;
    words_d     = words_q;
    pend_sts_d  = pend_sts_q;
    pend_reg_d  = pend_reg_q;
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_OP;
      pend_sts_d  = 1'b0;
      pend_reg_d  = '0;
    end else if (accept) begin
      if (state_q == S_K) begin
        out_valid_d = 1'b1;
        type_d      = pend_sts_q ? onehot(`TYPE_STS) : onehot(`TYPE_LDS);
        group_d     = group_of(type_d);
        rd_d        = pend_sts_q ? '0 : pend_reg_q;
        rr_d        = pend_sts_q ? pend_reg_q : '0;
        imd_d       = IMD_WIDTH'(instr[15:0]);
        words_d     = 1'b1;
        state_d     = S_OP;
        pend_sts_d  = 1'b0;
        pend_reg_d  = '0;
      end else if (dec_long) begin
        state_d    = S_K;
        pend_sts_d = dec_sts;
        pend_reg_d = dec_sts ? dec_rr : dec_rd;
      end else begin
        out_valid_d = 1'b1;
        type_d      = dec_type;
        group_d     = group_of(dec_type);
        rd_d        = dec_rd;
        rr_d        = dec_rr;
        imd_d       = dec_imd;
        words_d     = 1'b0;
      end
    end
  end

  // State and record registers; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OP;
      out_valid_q <= 1'b0;
      type_q      <= onehot(`TYPE_UNKNOWN);
      group_q     <= '0;
      rd_q        <= '0;
      rr_q        <= '0;
      imd_q       <= '0;
      words_q     <= 1'b0;
      pend_sts_q  <= 1'b0;
      pend_reg_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      type_q      <= type_d;
      group_q     <= group_d;
      rd_q        <= rd_d;
      rr_q        <= rr_d;
      imd_q       <= imd_d;
      words_q     <= words_d;
      pend_sts_q  <= pend_sts_d;
      pend_reg_q  <= pend_reg_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of single-word vectors streamed
// back-to-back, then hand sequences for stalls, two-word LDS/STS, flush and
// reset in the middle of a two-word instruction.

`ifndef DECODE_STAGE_DEFINES
`define DECODE_STAGE_DEFINES
`define OPCODE_COUNT        14
`define TYPE_UNKNOWN        0
`define TYPE_NOP            1
`define TYPE_ADD            2
`define TYPE_ADC            3
`define TYPE_SUB            4
`define TYPE_AND            5
`define TYPE_EOR            6
`define TYPE_OR             7
`define TYPE_MOV            8
`define TYPE_NEG            9
`define TYPE_LD_Y           10
`define TYPE_LDI            11
`define TYPE_LDS            12
`define TYPE_STS            13
`define GROUP_COUNT         11
`define GROUP_ALU_ONE_OP    0
`define GROUP_ALU_TWO_OP    1
`define GROUP_REGISTER      2
`define GROUP_LOAD_DIRECT   3
`define GROUP_LOAD_INDIRECT 4
`define GROUP_STORE_DIRECT  5
`define GROUP_STORE_INDIRECT 6
`define GROUP_ALU           7
`define GROUP_LOAD          8
`define GROUP_STORE         9
`define GROUP_MEMORY        10
`endif

module tb_decode_stage;

  localparam logic [10:0] G_NONE = 11'd0;
  localparam logic [10:0] G_ALU2 = 11'((1 << `GROUP_ALU_TWO_OP) | (1 << `GROUP_ALU));
  localparam logic [10:0] G_ALU1 = 11'((1 << `GROUP_ALU_ONE_OP) | (1 << `GROUP_ALU));
  localparam logic [10:0] G_REG  = 11'(1 << `GROUP_REGISTER);
  localparam logic [10:0] G_LDD  = 11'((1 << `GROUP_LOAD_DIRECT) | (1 << `GROUP_LOAD) | (1 << `GROUP_MEMORY));
  localparam logic [10:0] G_LDI  = 11'((1 << `GROUP_LOAD_INDIRECT) | (1 << `GROUP_LOAD) | (1 << `GROUP_MEMORY));
  localparam logic [10:0] G_STD  = 11'((1 << `GROUP_STORE_DIRECT) | (1 << `GROUP_STORE) | (1 << `GROUP_MEMORY));

  typedef struct {
    logic [15:0] instr;
    int          t;
    logic [10:0] grp;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [15:0] imd;
  } vec_t;

  logic clk;
  logic reset;
  logic flush;
  int   checks;
  int   errors;
  vec_t vecs[15];

  decode_stage_if #(.INSTR_WIDTH(16), .R_ADDR_WIDTH(5), .IMD_WIDTH(16)) bus ();
  decode_stage_if #(.INSTR_WIDTH(16), .R_ADDR_WIDTH(5), .IMD_WIDTH(16)) bus2 ();

  decode_stage #(
    .INSTR_WIDTH(16), .R_ADDR_WIDTH(5), .IMD_WIDTH(16),
    .LONG_MEM_EN(1'b1), .HIGH_REGS_ONLY(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  decode_stage #(
    .INSTR_WIDTH(16), .R_ADDR_WIDTH(5), .IMD_WIDTH(16),
    .LONG_MEM_EN(1'b0), .HIGH_REGS_ONLY(1'b1)
  ) dut_short (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus2)
  );

  assign bus2.in_instr  = bus.in_instr;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [52:0] ex(input logic v, input int t, input logic [10:0] g,
                                     input logic [4:0] rd, input logic [4:0] rr,
                                     input logic [15:0] imd, input logic w);
    logic [13:0] oh;
    oh = 14'd1 << t;
    return {v, oh, g, rd, rr, imd, w};
  endfunction

  function automatic logic [52:0] got1();
    return {bus.out_valid, bus.opcode_type, bus.opcode_group, bus.opcode_rd,
            bus.opcode_rr, bus.opcode_imd, bus.opcode_words};
  endfunction

  function automatic logic [52:0] got2();
    return {bus2.out_valid, bus2.opcode_type, bus2.opcode_group, bus2.opcode_rd,
            bus2.opcode_rr, bus2.opcode_imd, bus2.opcode_words};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{16'h0000, `TYPE_NOP,     G_NONE, 5'd0,  5'd0,  16'h0000};
    vecs[1]  = '{16'h0F01, `TYPE_ADD,     G_ALU2, 5'd16, 5'd17, 16'h0000};
    vecs[2]  = '{16'h1C5A, `TYPE_ADC,     G_ALU2, 5'd21, 5'd26, 16'h0000};
    vecs[3]  = '{16'h1801, `TYPE_SUB,     G_ALU2, 5'd16, 5'd17, 16'h0000};
    vecs[4]  = '{16'h2012, `TYPE_AND,     G_ALU2, 5'd17, 5'd18, 16'h0000};
    vecs[5]  = '{16'h2723, `TYPE_EOR,     G_ALU2, 5'd18, 5'd19, 16'h0000};
    vecs[6]  = '{16'h2834, `TYPE_OR,      G_ALU2, 5'd19, 5'd20, 16'h0000};
    vecs[7]  = '{16'h2F45, `TYPE_MOV,     G_REG,  5'd20, 5'd21, 16'h0000};
    vecs[8]  = '{16'h9551, `TYPE_NEG,     G_ALU1, 5'd21, 5'd0,  16'h0000};
    vecs[9]  = '{16'h8168, `TYPE_LD_Y,    G_LDI,  5'd22, 5'd0,  16'h0000};
    vecs[10] = '{16'hEA45, `TYPE_LDI,     G_REG,  5'd20, 5'd0,  16'h00A5};
    vecs[11] = '{16'hA3F7, `TYPE_LDS,     G_LDD,  5'd31, 5'd0,  16'h0057};
    vecs[12] = '{16'hAC28, `TYPE_STS,     G_STD,  5'd0,  5'd18, 16'h00A8};
    vecs[13] = '{16'hFFFF, `TYPE_UNKNOWN, G_NONE, 5'd0,  5'd0,  16'h0000};
    vecs[14] = '{16'h9400, `TYPE_UNKNOWN, G_NONE, 5'd0,  5'd0,  16'h0000};

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0000;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_record", 64'(got1()), 64'(ex(1'b0, `TYPE_UNKNOWN, G_NONE, 5'd0, 5'd0, 16'h0, 1'b0)));
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back single-word stream, one record per cycle.
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vecs[i].instr;
      tick();
      chk($sformatf("vec%0d_%h", i, vecs[i].instr), 64'(got1()),
          64'(ex(1'b1, vecs[i].t, vecs[i].grp, vecs[i].rd, vecs[i].rr, vecs[i].imd, 1'b0)));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Stall: LDI held while consumer is not ready; a pending ADD must wait.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hEA45;
    tick();
    bus.in_instr = 16'h0F01;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_hold%0d", k), 64'(got1()),
          64'(ex(1'b1, `TYPE_LDI, G_REG, 5'd20, 5'd0, 16'h00A5, 1'b0)));
      chk($sformatf("stall_in_ready%0d", k), 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("after_stall_add", 64'(got1()),
        64'(ex(1'b1, `TYPE_ADD, G_ALU2, 5'd16, 5'd17, 16'h0, 1'b0)));
    bus.in_valid = 1'b0;
    tick();
    chk("after_stall_empty", 64'(bus.out_valid), 64'd0);

    // LDS32 followed directly by its address word.
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h9120;
    tick();
    chk("lds32_first_no_out", 64'(bus.out_valid), 64'd0);
    chk("lds32_short_unknown", 64'(got2()),
        64'(ex(1'b1, `TYPE_UNKNOWN, G_NONE, 5'd0, 5'd0, 16'h0, 1'b0)));
    bus.in_instr = 16'h1234;
    tick();
    chk("lds32_record", 64'(got1()),
        64'(ex(1'b1, `TYPE_LDS, G_LDD, 5'd18, 5'd0, 16'h1234, 1'b1)));
    bus.in_valid = 1'b0;
    tick();

    // STS32 with an idle cycle before the address word.
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h9330;
    tick();
    chk("sts32_first_no_out", 64'(bus.out_valid), 64'd0);
    chk("sts32_short_unknown", 64'(got2()),
        64'(ex(1'b1, `TYPE_UNKNOWN, G_NONE, 5'd0, 5'd0, 16'h0, 1'b0)));
    bus.in_valid = 1'b0;
    tick();
    chk("sts32_idle_no_out", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h0100;
    tick();
    chk("sts32_record", 64'(got1()),
        64'(ex(1'b1, `TYPE_STS, G_STD, 5'd0, 5'd19, 16'h0100, 1'b1)));
    bus.in_valid = 1'b0;
    tick();

    // Flush while waiting for the address word; the flushed word is dropped.
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h9120;
    tick();
    flush        = 1'b1;
    bus.in_instr = 16'h1234;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    flush = 1'b0;
    chk("flush_no_out", 64'(bus.out_valid), 64'd0);
    bus.in_instr = 16'h0F01;
    tick();
    chk("flush_then_add", 64'(got1()),
        64'(ex(1'b1, `TYPE_ADD, G_ALU2, 5'd16, 5'd17, 16'h0, 1'b0)));
    bus.in_valid = 1'b0;
    tick();

    // Flush drops a record that the consumer is still holding off.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hEA45;
    tick();
    bus.in_valid = 1'b0;
    flush        = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_held_record", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;

    // Reset in the middle of a two-word instruction.
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h9120;
    tick();
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_k", 64'(got1()),
        64'(ex(1'b0, `TYPE_UNKNOWN, G_NONE, 5'd0, 5'd0, 16'h0, 1'b0)));
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h0F01;
    tick();
    chk("reset_mid_k_add", 64'(got1()),
        64'(ex(1'b1, `TYPE_ADD, G_ALU2, 5'd16, 5'd17, 16'h0, 1'b0)));
    bus.in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
